// File: rtl/rpm_pulse_gen.sv
// rpm_pulse_gen: tach pulse train generator with a programmable period in ms.
// A 1 ms timebase (treg) counts COUNT_MS clocks; mreg counts ms within a period.
// Optional burst mode is compiled in by defining PULSE_GEN_BURST_EN, which adds
// the burst_len input and done output.
module rpm_pulse_gen #(
    parameter int unsigned B        = 7,
    parameter int unsigned COUNT_MS = 50000,
    parameter int unsigned PULSE_W  = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic [B:0]   period_in,
`ifdef PULSE_GEN_BURST_EN
    input  logic [7:0]   burst_len,
    output logic         done,
`endif
    output logic         pulse_out,
    output logic         active,
    output logic [15:0]  pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_t;

    localparam logic [15:0] T_LAST = 16'(COUNT_MS - 1);
    localparam logic [15:0] P_LAST = 16'(PULSE_W - 1);
    localparam logic [B:0]  P_ONE  = {{B{1'b0}}, 1'b1};

    state_t      state, state_next;
    logic [B:0]  period_reg, period_act, period_act_next, next_period;
    logic [B:0]  mreg, mreg_next;
    logic [15:0] treg, treg_next, cnt_next;
    logic        pulse_next, active_next;
    logic        start_ok, period_end, start, burst_stop;

`ifdef PULSE_GEN_BURST_EN
    logic [7:0]  burst_cnt, burst_next;
    logic        armed, armed_next, done_next;
`endif

    // Effective period, start qualification and period-boundary detection
    always_comb begin
        next_period = load ? period_in : period_reg;
        period_end  = (state == LOW) && (mreg == period_act - P_ONE) && (treg == T_LAST);
`ifdef PULSE_GEN_BURST_EN
        burst_stop  = (burst_len != '0) && (burst_cnt == burst_len);
        start_ok    = enable && armed && (next_period != '0);
`else
        burst_stop  = 1'b0;
        start_ok    = enable && (next_period != '0);
`endif
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; unknown encodings fall back to IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start_ok) state_next = HIGH;
            HIGH: if (treg == P_LAST) state_next = LOW;
            LOW: begin
                if (period_end)
                    state_next = (start_ok && !burst_stop) ? HIGH : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of every registered output and counter
    always_comb begin
        start           = (state_next == HIGH) && (state != HIGH);
        period_act_next = period_act;
        treg_next       = treg;
        mreg_next       = mreg;
        cnt_next        = pulse_cnt;
        pulse_next      = pulse_out;
        active_next     = (state_next != IDLE);
`ifdef PULSE_GEN_BURST_EN
        burst_next      = burst_cnt;
        done_next       = period_end && burst_stop;
        armed_next      = enable ? (armed && !done_next) : 1'b1;
`endif
        if (start) begin
            period_act_next = next_period;
            treg_next       = '0;
            mreg_next       = '0;
            pulse_next      = 1'b1;
            cnt_next        = pulse_cnt + 16'd1;
`ifdef PULSE_GEN_BURST_EN
            burst_next      = (state == IDLE) ? 8'd1 : burst_cnt + 8'd1;
`endif
        end else begin
            unique case (state)
                HIGH: begin
                    treg_next = treg + 16'd1;
                    if (treg == P_LAST) pulse_next = 1'b0;
                end
                LOW: begin
                    if (treg == T_LAST) begin
                        treg_next = '0;
                        mreg_next = mreg + P_ONE;
                    end else begin
                        treg_next = treg + 16'd1;
                    end
                end
                default: pulse_next = 1'b0;
            endcase
        end
    end

    // Period register: load is honoured in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     period_reg <= '0;
        else if (load) period_reg <= period_in;
    end

    // Registered outputs and timing counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_act <= '0;
            treg       <= '0;
            mreg       <= '0;
            pulse_out  <= 1'b0;
            active     <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            period_act <= period_act_next;
            treg       <= treg_next;
            mreg       <= mreg_next;
            pulse_out  <= pulse_next;
            active     <= active_next;
            pulse_cnt  <= cnt_next;
        end
    end

`ifdef PULSE_GEN_BURST_EN
    // Burst bookkeeping: pulse count within the burst, done strobe, re-arm flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt <= '0;
            done      <= 1'b0;
            armed     <= 1'b1;
        end else begin
            burst_cnt <= burst_next;
            done      <= done_next;
            armed     <= armed_next;
        end
    end
`endif

endmodule
